// File: rtl/stream_demux_1ton_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-N stream demultiplexer.
//   N_OUT_MAX / DATA_W_MAX : supported upper limits for channel count and width
//   chan_slice(k, w)       : bit offset of channel k inside a flat N*w bus
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int N_OUT_MAX  = 32;
  localparam int DATA_W_MAX = 64;

  function automatic int chan_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/stream_demux_1ton_if.sv
// -----------------------------------------------------------------------------
// stream_demux_if
// Producer-side valid/ready stream plus N consumer-side valid/ready channels.
//   clk       : bus clock (carried for observers of the interface)
//   in_*      : single producer beat (valid, ready, data, select, broadcast)
//   out_*     : per-channel valid/ready and flat data bus, channel k at
//               out_data[k*DATA_W +: DATA_W]
// Modports: master = producer/consumer side (testbench), slave = demux.
// -----------------------------------------------------------------------------
interface stream_demux_if #(
  parameter int N_OUT  = 8,
  parameter int DATA_W = 8
) (
  input logic clk
);
  localparam int SEL_W = $clog2(N_OUT);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT-1:0]          out_ready;
  logic [N_OUT*DATA_W-1:0]   out_data;

  modport master (
    input  clk,
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  clk,
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux_1ton_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
// One-entry output register for a single demux channel.
//   clk, rst : clock, asynchronous active-high reset
//   i_load   : capture i_data this edge (wins over a simultaneous drain)
//   i_data   : payload to capture
//   i_ready  : consumer takes the held beat this edge
//   o_valid  : slot holds a beat
//   o_data   : held payload
// -----------------------------------------------------------------------------
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Load has priority so a drain and a refill in the same cycle keep the
  // slot valid with the new beat: one beat per cycle per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/stream_demux_1ton.sv
// -----------------------------------------------------------------------------
// stream_demux_1ton
// 1-to-N stream demultiplexer with a registered slot per channel, broadcast
// mode and a saturating counter of beats dropped for an out-of-range select.
//   clk, rst  : clock, asynchronous active-high reset
//   s         : stream_demux_if slave (producer beat in, N channels out)
//   drop_cnt  : beats accepted with in_sel >= N_OUT (unicast), saturating
// in_ready depends only on in_sel, in_bcast, out_ready and slot state.
// -----------------------------------------------------------------------------
module stream_demux_1ton
  import demux_pkg::*;
#(
  parameter int N_OUT  = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  stream_demux_if.slave     s,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int NPAD = 1 << SEL_W;

  logic [N_OUT-1:0] w_free;
  logic [N_OUT-1:0] w_load;
  logic [N_OUT-1:0] w_slot_vld;
  logic [NPAD-1:0]  w_free_pad;
  logic             w_sel_ok;
  logic             w_all_free;
  logic             w_acc;
  logic             w_drop;
  logic [CNT_W-1:0] r_drop_cnt;

  assign w_free     = ~w_slot_vld | s.out_ready;
  assign w_all_free = &w_free;

  // Select codes past N_OUT read as "free": such beats are always accepted
  // and then dropped.
  always_comb begin
    w_free_pad             = '1;
    w_free_pad[N_OUT-1:0]  = w_free;
  end

  if (NPAD == N_OUT) begin : g_pow2
    assign w_sel_ok = 1'b1;
  end else begin : g_npow2
    assign w_sel_ok = (s.in_sel < SEL_W'(N_OUT));
  end

  assign s.in_ready = s.in_bcast ? w_all_free : w_free_pad[s.in_sel];
  assign w_acc      = s.in_valid & s.in_ready;
  assign w_drop     = w_acc & ~s.in_bcast & ~w_sel_ok;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign w_load[k] = w_acc & (s.in_bcast | (s.in_sel == SEL_W'(k)));

    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (s.in_data),
      .i_ready (s.out_ready[k]),
      .o_valid (w_slot_vld[k]),
      .o_data  (s.out_data[chan_slice(k, DATA_W) +: DATA_W])
    );
  end

  assign s.out_valid = w_slot_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux_1ton.sv
module tb_stream_demux_1ton;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_if #(.N_OUT(8), .DATA_W(8)) if8 (.clk(clk));
  stream_demux_if #(.N_OUT(6), .DATA_W(8)) if6 (.clk(clk));

  logic [15:0] drop8;
  logic [1:0]  drop6;

  stream_demux_1ton #(.N_OUT(8), .DATA_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .s(if8.slave), .drop_cnt(drop8));
  stream_demux_1ton #(.N_OUT(6), .DATA_W(8), .CNT_W(2)) dut6 (
    .clk(clk), .rst(rst), .s(if6.slave), .drop_cnt(drop6));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- signal access, index 0 = 8-channel DUT, 1 = 6-channel DUT
  function automatic int nch(input int d);  return (d == 0) ? 8 : 6; endfunction
  function automatic int cmax(input int d); return (d == 0) ? 65535 : 3; endfunction

  function automatic logic [7:0] g_vld(input int d);
    return (d == 0) ? if8.out_valid : {2'b00, if6.out_valid};
  endfunction
  function automatic logic [63:0] g_dat(input int d);
    return (d == 0) ? if8.out_data : {16'h0, if6.out_data};
  endfunction
  function automatic logic [7:0] g_ordy(input int d);
    return (d == 0) ? if8.out_ready : {2'b00, if6.out_ready};
  endfunction
  function automatic logic g_rdy(input int d); return (d == 0) ? if8.in_ready : if6.in_ready; endfunction
  function automatic logic g_iv(input int d);  return (d == 0) ? if8.in_valid : if6.in_valid; endfunction
  function automatic logic g_bc(input int d);  return (d == 0) ? if8.in_bcast : if6.in_bcast; endfunction
  function automatic logic [2:0] g_sel(input int d); return (d == 0) ? if8.in_sel : if6.in_sel; endfunction
  function automatic logic [7:0] g_din(input int d); return (d == 0) ? if8.in_data : if6.in_data; endfunction
  function automatic int g_drop(input int d); return (d == 0) ? int'(drop8) : int'(drop6); endfunction

  function automatic logic [7:0] lane(input int d, input int k);
    logic [63:0] v;
    v = g_dat(d);
    return v[k*8 +: 8];
  endfunction

  task automatic drive(input int d, input logic v, input logic [2:0] sel,
                       input logic b, input logic [7:0] dat);
    if (d == 0) begin
      if8.in_valid = v; if8.in_sel = sel; if8.in_bcast = b; if8.in_data = dat;
    end else begin
      if6.in_valid = v; if6.in_sel = sel; if6.in_bcast = b; if6.in_data = dat;
    end
  endtask

  task automatic set_ordy(input int d, input logic [7:0] r);
    if (d == 0) if8.out_ready = r;
    else        if6.out_ready = r[5:0];
  endtask

  // ---------------- reference model: per-channel queues of undelivered beats
  logic [7:0] mq [2][8][$];
  int         mdrop [2];
  logic       cap_acc [2];
  logic       cap_bc [2];
  logic [2:0] cap_sel [2];
  logic [7:0] cap_dat [2];
  logic [7:0] cap_ordy [2];
  logic       hold [2];

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) mq[d][k].delete();
      mdrop[d] = 0;
      hold[d]  = 1'b0;
    end
  endfunction

  // A channel can take a beat when nothing is pending there or the pending
  // beat leaves this cycle.
  function automatic logic m_ready(input int d);
    logic [7:0] r;
    r = g_ordy(d);
    if (g_bc(d)) begin
      for (int k = 0; k < nch(d); k++)
        if (mq[d][k].size() != 0 && !r[k]) return 1'b0;
      return 1'b1;
    end
    if (int'(g_sel(d)) >= nch(d)) return 1'b1;
    return (mq[d][g_sel(d)].size() == 0) || r[g_sel(d)];
  endfunction

  task automatic model_check(input int d);
    logic [7:0] ev;
    int         ed;
    chk($sformatf("d%0d in_ready", d), 64'(g_rdy(d)), 64'(m_ready(d)));
    ev = '0;
    for (int k = 0; k < nch(d); k++) ev[k] = (mq[d][k].size() != 0);
    chk($sformatf("d%0d out_valid", d), 64'(g_vld(d)), 64'(ev));
    for (int k = 0; k < nch(d); k++)
      if (mq[d][k].size() != 0)
        chk($sformatf("d%0d out_data[%0d]", d, k), 64'(lane(d, k)), 64'(mq[d][k][0]));
    ed = (mdrop[d] > cmax(d)) ? cmax(d) : mdrop[d];
    chk($sformatf("d%0d drop_cnt", d), 64'(g_drop(d)), 64'(ed));
  endtask

  function automatic void model_apply(input int d);
    for (int k = 0; k < nch(d); k++)
      if (mq[d][k].size() != 0 && cap_ordy[d][k]) void'(mq[d][k].pop_front());
    if (cap_acc[d]) begin
      if (cap_bc[d]) begin
        for (int k = 0; k < nch(d); k++) mq[d][k].push_back(cap_dat[d]);
      end else if (int'(cap_sel[d]) < nch(d)) begin
        mq[d][cap_sel[d]].push_back(cap_dat[d]);
      end else begin
        mdrop[d]++;
      end
    end
  endfunction

  // One clock: check both DUTs mid-cycle, record the handshake, advance model.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_check(d);
      cap_acc[d]  = g_iv(d) && m_ready(d);
      hold[d]     = g_iv(d) && !m_ready(d);
      cap_bc[d]   = g_bc(d);
      cap_sel[d]  = g_sel(d);
      cap_dat[d]  = g_din(d);
      cap_ordy[d] = g_ordy(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_apply(d);
    #1;
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic [2:0]  sel;
    logic        bcast;
    logic [7:0]  data;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_vld;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [63:0] acc;

    rst = 1'b1;
    m_reset();
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 3'd0, 1'b0, 8'h00);
      set_ordy(d, 8'hFF);
    end

    acc = '0;
    for (int k = 0; k < 8; k++) begin
      acc[k*8 +: 8] = 8'(8'hA0 + k);
      tbl[k] = '{sel: 3'(k), bcast: 1'b0, data: 8'(8'hA0 + k), ordy: 8'hFF,
                 exp_rdy: 1'b1, exp_vld: 8'(1 << k), exp_data: acc};
    end
    tbl[8] = '{sel: 3'd0, bcast: 1'b1, data: 8'hBC, ordy: 8'hFF,
               exp_rdy: 1'b1, exp_vld: 8'hFF, exp_data: {8{8'hBC}}};
    acc = {8{8'hBC}};
    acc[23:16] = 8'h5A;
    tbl[9] = '{sel: 3'd2, bcast: 1'b0, data: 8'h5A, ordy: 8'hFF,
               exp_rdy: 1'b1, exp_vld: 8'h04, exp_data: acc};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst d%0d out_valid", d), 64'(g_vld(d)), 64'h0);
      chk($sformatf("rst d%0d out_data", d),  g_dat(d), 64'h0);
      chk($sformatf("rst d%0d drop_cnt", d),  64'(g_drop(d)), 64'h0);
      chk($sformatf("rst d%0d in_ready", d),  64'(g_rdy(d)), 64'h1);
    end

    // Unicast sweep, broadcast, unicast overwrite: one beat per cycle
    for (int i = 0; i < 10; i++) begin
      set_ordy(0, tbl[i].ordy);
      drive(0, 1'b1, tbl[i].sel, tbl[i].bcast, tbl[i].data);
      #1;
      chk($sformatf("vec%0d in_ready", i), 64'(if8.in_ready), 64'(tbl[i].exp_rdy));
      cycle();
      chk($sformatf("vec%0d out_valid", i), 64'(if8.out_valid), 64'(tbl[i].exp_vld));
      chk($sformatf("vec%0d out_data", i), if8.out_data, tbl[i].exp_data);
    end
    drive(0, 1'b0, 3'd0, 1'b0, 8'h00);

    // Back-pressure on channel 3
    set_ordy(0, 8'hF7);
    drive(0, 1'b1, 3'd3, 1'b0, 8'h11);
    cycle();
    drive(0, 1'b1, 3'd3, 1'b0, 8'h22);
    #1 chk("bp in_ready stalled", 64'(if8.in_ready), 64'h0);
    cycle();
    cycle();
    chk("bp ch3 holds 11", 64'(lane(0, 3)), 64'h11);
    chk("bp ch3 valid", 64'(if8.out_valid[3]), 64'h1);
    set_ordy(0, 8'hFF);
    #1 chk("bp in_ready released", 64'(if8.in_ready), 64'h1);
    cycle();
    chk("bp ch3 shows 22", 64'(lane(0, 3)), 64'h22);
    chk("bp ch3 valid after reload", 64'(if8.out_valid[3]), 64'h1);
    drive(0, 1'b1, 3'd5, 1'b0, 8'h55);
    cycle();
    chk("bp ch5 shows 55", 64'(lane(0, 5)), 64'h55);
    chk("bp valid after 55", 64'(if8.out_valid), 64'h20);
    drive(0, 1'b0, 3'd0, 1'b0, 8'h00);
    cycle();

    // Broadcast stalled by one occupied channel
    set_ordy(0, 8'hBF);
    drive(0, 1'b1, 3'd6, 1'b0, 8'h66);
    cycle();
    drive(0, 1'b1, 3'd0, 1'b1, 8'hBC);
    #1 chk("bc in_ready stalled", 64'(if8.in_ready), 64'h0);
    cycle();
    cycle();
    chk("bc nothing written", 64'(if8.out_valid), 64'h40);
    chk("bc ch6 still 66", 64'(lane(0, 6)), 64'h66);
    set_ordy(0, 8'hFF);
    cycle();
    chk("bc all valid", 64'(if8.out_valid), 64'hFF);
    chk("bc all data", if8.out_data, {8{8'hBC}});
    drive(0, 1'b0, 3'd0, 1'b0, 8'h00);
    cycle();

    // Invalid selects on the 6-channel DUT, 2-bit saturating counter
    drive(1, 1'b1, 3'd6, 1'b0, 8'hE6);
    #1 chk("inv sel6 in_ready", 64'(if6.in_ready), 64'h1);
    cycle();
    chk("inv sel6 no valid", 64'(if6.out_valid), 64'h0);
    drive(1, 1'b1, 3'd7, 1'b0, 8'hE7);
    #1 chk("inv sel7 in_ready", 64'(if6.in_ready), 64'h1);
    cycle();
    chk("inv no valid", 64'(if6.out_valid), 64'h0);
    chk("inv drop_cnt 2", 64'(drop6), 64'h2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 3'(6 + (i % 2)), 1'b0, 8'(i));
      cycle();
    end
    chk("inv drop_cnt saturated", 64'(drop6), 64'h3);
    drive(1, 1'b0, 3'd0, 1'b0, 8'h00);
    cycle();

    // Asynchronous reset mid-stream with channels 1 and 4 holding beats
    set_ordy(0, 8'hED);
    drive(0, 1'b1, 3'd1, 1'b0, 8'h31);
    cycle();
    drive(0, 1'b1, 3'd4, 1'b0, 8'h34);
    cycle();
    drive(0, 1'b0, 3'd0, 1'b0, 8'h00);
    chk("ar valid before reset", 64'(if8.out_valid), 64'h12);
    #2 rst = 1'b1;
    #1;
    chk("ar out_valid cleared", 64'(if8.out_valid), 64'h0);
    chk("ar out_data cleared", if8.out_data, 64'h0);
    chk("ar drop_cnt cleared", 64'(drop6), 64'h0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_ordy(0, 8'hFF);
    drive(0, 1'b1, 3'd2, 1'b0, 8'h77);
    cycle();
    chk("ar first beat valid", 64'(if8.out_valid), 64'h04);
    chk("ar first beat data", 64'(lane(0, 2)), 64'h77);
    drive(0, 1'b0, 3'd0, 1'b0, 8'h00);
    cycle();

    // Random traffic on both DUTs, holding any stalled beat unchanged
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        set_ordy(d, 8'($urandom) | 8'($urandom));
        if (!hold[d])
          drive(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0), 8'($urandom));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
